reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised integer register file with a built-in scoreboard. It sits between decode and writeback. It provides NRD combinational read ports with same-cycle write-to-read bypass and one clocked write port. A per-register busy bit is set when an instruction claims a destination and cleared when that register is written back. Decode uses the per-port busy flags to stall on RAW hazards, and a flush input drops all outstanding claims.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs_en  in  NRD  per-port read enable.
- rs_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy  out  NRD  port i's register has an outstanding producer.
- wb_en  in  1  write enable.
- wb_addr  in  AW  write address.
- wb_data  in  XLEN  write data.
- claim_en  in  1  mark claim_addr busy (issue of a producing instruction).
- claim_addr  in  AW  destination being claimed.
- flush  in  1  clear all busy bits (pipeline flush).
- busy_cnt  out  AW+1  number of busy registers.

## Operation
- State: regs[0..NREGS-1] (XLEN each) and busy[NREGS-1:0].
- Register 0 is hardwired: it always reads 0 and its busy bit is always 0. Writes and claims to address 0 are ignored.
- Each read port i is purely combinational and has the following priority:
  - rst=1 or rs_en[i]=0: rs_data=0, rs_busy=0.
  - addr=0: rs_data=0, rs_busy=0.
  - wb_en=1 and wb_addr==addr: rs_data=wb_data (bypass), rs_busy=0.
  - Otherwise: rs_data=regs[addr], rs_busy=busy[addr].
- Write: on the clock edge with wb_en=1 and wb_addr≠0, regs[wb_addr] takes wb_data.
- The busy next-state for each register r≠0 is evaluated in this order:
  - Start from busy[r].
  - If flush=1, clear it.
  - Else, if wb_en=1 and wb_addr==r, clear it.
  - Then, if claim_en=1 and claim_addr==r, set it. Claim wins over both writeback and flush.
- busy_cnt is registered and equals the popcount of busy, updated on the same edge as busy.
- A write to a register that is not busy is legal; its data is still written.
- A claim of a register that is already busy is legal; the bit stays 1, since there is no counting.

## Timing
- Reset (asynchronous on rst rising): all regs=0, busy=0, busy_cnt=0. While rst=1, rs_data=0 and rs_busy=0 on all ports.
  - On rst deassertion, the first edge with rst=0 performs normal updates.
  - Reset asserted mid-operation discards any writeback or claim in that cycle.
- Read latency: 0 cycles (combinational from rs_addr, rs_en, wb_*).
- Write visibility:
  - Same cycle via bypass.
  - From the stored array starting on the cycle after the write edge.
- Claim visibility: rs_busy for a claimed register rises the cycle after the claim edge.
- Writeback release: rs_busy drops in the same cycle that wb_en/wb_addr are presented (bypass path); busy[r] clears on that edge.
- Simultaneous claim and wb to the same r:
  - Reader sees the bypassed wb_data with rs_busy=0 that cycle.
  - busy[r]=1 after the edge.
- Simultaneous flush and claim: after the edge, only claim_addr is busy and busy_cnt=1.
- Multiple read ports with equal addresses return identical data and busy values.
- No handshake back-pressure: every valid input is consumed in one cycle.

## Test plan
- Reset: hold rst, drive rs_en=all 1, rs_addr=5 → rs_data=0, rs_busy=0. After release, busy_cnt=0 and every reg reads 0.
- Write/read: wb x7=0xDEADBEEF at edge N, with no wb at N+1, read x7 on port 1 at N+1 → 0xDEADBEEF. Write to x0 with 0x1234 → x0 still reads 0.
- Bypass: read x3 on port 0 in the same cycle that wb_en=1, wb_addr=3, wb_data=0xA5A5A5A5 → rs_data=0xA5A5A5A5. Old value observed only with wb_en=0.
- Scoreboard: claim x9 at edge N → rs_busy=1 and busy_cnt=1 at N+1. wb x9=0x42 at N+2 → rs_busy=0 and rs_data=0x42 in that cycle, busy_cnt=0 after the edge.
- Collision: claim x4 and wb x4=0x11 in the same cycle → reader gets 0x11, rs_busy=0 that cycle. Next cycle rs_busy=1, busy_cnt=1.
- Flush: claim x1, x2, x3 on successive edges (busy_cnt=3), then flush together with claim x6 → busy_cnt=1, only x6 busy, and register data unchanged.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if -- bus between decode/writeback and the scoreboarded register file.
// Read side : rs_en / rs_addr in, rs_data / rs_busy out (NRD ports, packed per port).
// Write side: wb_en / wb_addr / wb_data.
// Scoreboard: claim_en / claim_addr, flush, and busy_cnt out.
// master = pipeline (decode/writeback), slave = register file.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic [NRD-1:0]      rs_en;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rs_en, rs_addr, wb_en, wb_addr, wb_data, claim_en, claim_addr, flush,
    input  rs_data, rs_busy, busy_cnt
  );

  modport slave (
    input  rs_en, rs_addr, wb_en, wb_addr, wb_data, claim_en, claim_addr, flush,
    output rs_data, rs_busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb -- integer register file with a per-register busy scoreboard.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : reg_file_sb_if.slave (read ports, writeback, claim, flush, busy_cnt)
// Reads are combinational with same-cycle writeback bypass; x0 is hardwired
// to zero and never busy. A claim on the same edge as a writeback or flush wins.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;
  logic [NREGS-1:0] w_busy_nxt;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] n;
    n = {(AW+1){1'b0}};
    for (int k = 0; k < NREGS; k++) begin
      n = n + {{AW{1'b0}}, v[k]};
    end
    return n;
  endfunction

  // Next busy vector: flush or writeback release first, then claim sets on top.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.flush) begin
      w_busy_nxt = {NREGS{1'b0}};
    end else if (bus.wb_en) begin
      w_busy_nxt[bus.wb_addr] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (bus.claim_en) begin
      w_busy_nxt[bus.claim_addr] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Register array write port; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
    end else if (bus.wb_en && (bus.wb_addr != {AW{1'b0}})) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= {NREGS{1'b0}};
      r_busy_cnt <= {(AW+1){1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcount(w_busy_nxt);
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_bsy;

    assign w_addr = bus.rs_addr[i*AW +: AW];

    // Read mux: disabled/reset, x0, writeback bypass, then stored state.
    always_comb begin
      w_data = {XLEN{1'b0}};
      w_bsy  = 1'b0;
      if (rst || !bus.rs_en[i]) begin
        w_data = {XLEN{1'b0}};
        w_bsy  = 1'b0;
      end else if (w_addr == {AW{1'b0}}) begin
        w_data = {XLEN{1'b0}};
        w_bsy  = 1'b0;
      end else if (bus.wb_en && (bus.wb_addr == w_addr)) begin
        // The producer is writing back now, so the consumer need not stall.
        w_data = bus.wb_data;
        w_bsy  = 1'b0;
      end else begin
        w_data = r_regs[w_addr];
        w_bsy  = r_busy[w_addr];
      end
    end

    assign bus.rs_data[i*XLEN +: XLEN] = w_data;
    assign bus.rs_busy[i]              = w_bsy;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all checked against an array/bit-level reference model.
module tb_reg_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] pdata(input int i);
    return bus.rs_data[i*XLEN +: XLEN];
  endfunction

  task automatic idle();
    bus.rs_en = '0; bus.rs_addr = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.claim_en = 1'b0; bus.claim_addr = '0; bus.flush = 1'b0;
  endtask

  task automatic rd(input int i, input int a);
    bus.rs_en[i] = 1'b1;
    bus.rs_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic wb(input int a, input logic [XLEN-1:0] d);
    bus.wb_en = 1'b1; bus.wb_addr = AW'(a); bus.wb_data = d;
  endtask

  task automatic claim(input int a);
    bus.claim_en = 1'b1; bus.claim_addr = AW'(a);
  endtask

  // Let combinational outputs settle, then compare every port and busy_cnt.
  task automatic check_all(input string tag);
    logic [XLEN-1:0] ed;
    logic            eb;
    int              a;
    #1;
    for (int i = 0; i < NRD; i++) begin
      a = int'(bus.rs_addr[i*AW +: AW]);
      ed = '0; eb = 1'b0;
      if (rst || !bus.rs_en[i] || a == 0) begin
        ed = '0; eb = 1'b0;
      end else if (bus.wb_en && int'(bus.wb_addr) == a) begin
        ed = bus.wb_data; eb = 1'b0;
      end else begin
        ed = m_regs[a]; eb = m_busy[a];
      end
      check($sformatf("%s.data%0d", tag, i), 64'(pdata(i)), 64'(ed));
      check($sformatf("%s.busy%0d", tag, i), 64'(bus.rs_busy[i]), 64'(eb));
    end
    check($sformatf("%s.cnt", tag), 64'(bus.busy_cnt), 64'(m_cnt()));
  endtask

  // One clock edge; the model applies the inputs that were held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.flush) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      end else if (bus.wb_en) begin
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (bus.claim_en) m_busy[bus.claim_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    #1;
  endtask

  initial begin
    m_clear();
    idle();
    rst = 1'b1;

    // Reset: outputs forced to zero while rst is high.
    rd(0, 5); rd(1, 5);
    tick();
    check_all("reset");
    check("reset.d0", 64'(pdata(0)), 64'd0);
    check("reset.b", 64'(bus.rs_busy), 64'd0);
    rst = 1'b0;
    check_all("rel");
    check("rel.cnt", 64'(bus.busy_cnt), 64'd0);
    for (int r = 0; r < NREGS; r += 2) begin
      rd(0, r); rd(1, r + 1);
      check_all("rel.sweep");
    end

    // Write then read from the array.
    idle(); wb(7, 32'hDEADBEEF); tick();
    idle(); rd(1, 7);
    check_all("wr7");
    check("wr7.lit", 64'(pdata(1)), 64'h0000_0000_DEAD_BEEF);
    idle(); wb(0, 32'h1234); rd(0, 0); tick();
    idle(); rd(0, 0);
    check_all("wr0");
    check("wr0.lit", 64'(pdata(0)), 64'd0);

    // Bypass: old value without wb, new value in the wb cycle.
    idle(); wb(3, 32'h1111_2222); tick();
    idle(); rd(0, 3);
    check_all("byp.old");
    check("byp.old.lit", 64'(pdata(0)), 64'h1111_2222);
    wb(3, 32'hA5A5A5A5);
    check_all("byp.new");
    check("byp.new.lit", 64'(pdata(0)), 64'hA5A5_A5A5);
    tick();

    // Scoreboard claim and release.
    idle(); claim(9); rd(0, 9); tick();
    idle(); rd(0, 9);
    check_all("sb.claim");
    check("sb.claim.busy", 64'(bus.rs_busy[0]), 64'd1);
    check("sb.claim.cnt", 64'(bus.busy_cnt), 64'd1);
    tick();
    wb(9, 32'h42);
    check_all("sb.wb");
    check("sb.wb.busy", 64'(bus.rs_busy[0]), 64'd0);
    check("sb.wb.data", 64'(pdata(0)), 64'h42);
    tick();
    idle(); rd(0, 9);
    check_all("sb.after");
    check("sb.after.cnt", 64'(bus.busy_cnt), 64'd0);

    // Claim and writeback to the same register in one cycle.
    idle(); claim(4); wb(4, 32'h11); rd(1, 4);
    check_all("col");
    check("col.data", 64'(pdata(1)), 64'h11);
    check("col.busy", 64'(bus.rs_busy[1]), 64'd0);
    tick();
    idle(); rd(1, 4);
    check_all("col.next");
    check("col.next.busy", 64'(bus.rs_busy[1]), 64'd1);
    check("col.next.cnt", 64'(bus.busy_cnt), 64'd1);
    idle(); wb(4, 32'h11); tick();

    // Flush together with a claim.
    idle(); claim(1); tick();
    idle(); claim(2); tick();
    idle(); claim(3); tick();
    idle(); rd(0, 3);
    check_all("fl.pre");
    check("fl.pre.cnt", 64'(bus.busy_cnt), 64'd3);
    bus.flush = 1'b1; claim(6); tick();
    idle(); rd(0, 6); rd(1, 3);
    check_all("fl.post");
    check("fl.post.cnt", 64'(bus.busy_cnt), 64'd1);
    check("fl.post.b6", 64'(bus.rs_busy[0]), 64'd1);
    check("fl.post.x3", 64'(pdata(1)), 64'hA5A5_A5A5);

    // Random traffic on a narrow address range so hits and collisions are common.
    for (int c = 0; c < 600; c++) begin
      idle();
      bus.rs_en      = NRD'($urandom);
      bus.rs_addr[0 +: AW]  = AW'($urandom_range(0, 7));
      bus.rs_addr[AW +: AW] = ($urandom_range(0, 3) == 0) ? bus.rs_addr[0 +: AW]
                                                          : AW'($urandom_range(0, 7));
      bus.wb_en      = 1'($urandom);
      bus.wb_addr    = AW'($urandom_range(0, 7));
      bus.wb_data    = XLEN'($urandom);
      bus.claim_en   = 1'($urandom);
      bus.claim_addr = AW'($urandom_range(0, 7));
      bus.flush      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        m_clear();
        check_all("rnd.rst");
        tick();
        rst = 1'b0;
      end else begin
        check_all("rnd");
        tick();
      end
    end
    idle();
    check_all("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
